// File: rtl/sad_pkg.sv
// Shared types and width helpers for the SAD motion-search controller and
// anything that connects to the registered SAD unit.
package sad_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sad_state_e;

   // Never return a zero-width field, even for degenerate sizes.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int row_sad_w(input int width, input int inputs);
      return width + $clog2(inputs);
   endfunction

   function automatic int blk_sad_w(input int width, input int inputs, input int rows);
      return row_sad_w(width, inputs) + $clog2(rows);
   endfunction

   function automatic int cur_addr_w(input int rows);
      return clog2_min1(rows);
   endfunction

   function automatic int ref_addr_w(input int cands, input int rows);
      return clog2_min1(cands + rows - 1);
   endfunction

   function automatic int idx_w(input int cands);
      return clog2_min1(cands);
   endfunction

endpackage

// File: rtl/sad_min_tracker.sv
// Accumulates tagged row SADs into block SADs and keeps the smallest block SAD
// together with the candidate index that produced it.
module sad_min_tracker
   import sad_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int INPUTS = 4,
   parameter int ROWS   = 4,
   parameter int CANDS  = 8
)(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   clr,
   input  logic                                   vld,
   input  logic                                   first,
   input  logic                                   last,
   input  logic [idx_w(CANDS)-1:0]                cand,
   input  logic [row_sad_w(WIDTH, INPUTS)-1:0]    sad_in,
   output logic [blk_sad_w(WIDTH, INPUTS, ROWS)-1:0] best_sad,
   output logic [idx_w(CANDS)-1:0]                best_idx
);

   localparam int RSW = row_sad_w(WIDTH, INPUTS);
   localparam int BSW = blk_sad_w(WIDTH, INPUTS, ROWS);

   logic [BSW-1:0] acc;
   logic [BSW-1:0] sad_ext;
   logic [BSW-1:0] blk;

   function automatic logic [BSW-1:0] widen(input logic [RSW-1:0] x);
      return BSW'(x);
   endfunction

   assign sad_ext = widen(sad_in);
   // A first row restarts the sum; this also covers single-row blocks.
   assign blk     = first ? sad_ext : acc + sad_ext;

   always_ff @(posedge clk) begin
      if (clr)
         acc <= '0;
      else if (vld)
         acc <= blk;
   end

   // Strict less-than: on equal SADs the earlier (lower) candidate stays.
   always_ff @(posedge clk) begin
      if (rst) begin
         best_sad <= '0;
         best_idx <= '0;
      end else if (clr) begin
         best_sad <= '1;
         best_idx <= '0;
      end else if (vld && last && (blk < best_sad)) begin
         best_sad <= blk;
         best_idx <= cand;
      end
   end

endmodule

// File: rtl/sad_search_ctrl.sv
// Vertical block-matching search sequencer: issues row reads for every
// candidate, tags them through the memory + SAD latency, and tracks the best.
module sad_search_ctrl
   import sad_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int INPUTS = 4,
   parameter int ROWS   = 4,
   parameter int CANDS  = 8
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      rd_en,
   output logic [cur_addr_w(ROWS)-1:0]               cur_addr,
   output logic [ref_addr_w(CANDS, ROWS)-1:0]        ref_addr,
   input  logic [row_sad_w(WIDTH, INPUTS)-1:0]       sad_in,
   output logic [blk_sad_w(WIDTH, INPUTS, ROWS)-1:0] best_sad,
   output logic [idx_w(CANDS)-1:0]                   best_idx
);

   localparam int CAW = cur_addr_w(ROWS);
   localparam int RAW = ref_addr_w(CANDS, ROWS);
   localparam int IW  = idx_w(CANDS);

   localparam logic [CAW-1:0] ROW_LAST  = CAW'(ROWS - 1);
   localparam logic [IW-1:0]  CAND_LAST = IW'(CANDS - 1);

   sad_state_e     state;
   logic [CAW-1:0] r;
   logic [IW-1:0]  c;
   logic           drain_cnt;
   logic           clr;

   logic           vld_p0, vld_p1;
   logic           first_p0, first_p1;
   logic           last_p0, last_p1;
   logic [IW-1:0]  cand_p0, cand_p1;

   function automatic logic [RAW-1:0] ref_sum(input logic [IW-1:0] cc, input logic [CAW-1:0] rr);
      return RAW'(cc) + RAW'(rr);
   endfunction

   assign clr = (state == IDLE) && start;

   // Addresses are registered alongside the counters so they leave the block
   // straight from flops; r/c always describe the row being issued this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         cur_addr  <= '0;
         ref_addr  <= '0;
         r         <= '0;
         c         <= '0;
         drain_cnt <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= ISSUE;
                  busy     <= 1'b1;
                  rd_en    <= 1'b1;
                  r        <= '0;
                  c        <= '0;
                  cur_addr <= '0;
                  ref_addr <= '0;
               end
            end
            ISSUE: begin
               if (r == ROW_LAST) begin
                  if (c == CAND_LAST) begin
                     state     <= DRAIN;
                     rd_en     <= 1'b0;
                     drain_cnt <= 1'b0;
                     cur_addr  <= '0;
                     ref_addr  <= '0;
                  end else begin
                     r        <= '0;
                     c        <= c + 1'b1;
                     cur_addr <= '0;
                     ref_addr <= ref_sum(c + 1'b1, '0);
                  end
               end else begin
                  r        <= r + 1'b1;
                  cur_addr <= r + 1'b1;
                  ref_addr <= ref_sum(c, r + 1'b1);
               end
            end
            DRAIN: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // p0: memory read in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= rd_en;
         vld_p1 <= vld_p0;
      end
   end

   always_ff @(posedge clk) begin
      first_p0 <= (r == '0);
      last_p0  <= (r == ROW_LAST);
      cand_p0  <= c;
      // p1: SAD unit register stage, sad_in belongs to this tag
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      cand_p1  <= cand_p0;
   end

   sad_min_tracker #(
      .WIDTH  (WIDTH),
      .INPUTS (INPUTS),
      .ROWS   (ROWS),
      .CANDS  (CANDS)
   ) u_tracker (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .vld      (vld_p1),
      .first    (first_p1),
      .last     (last_p1),
      .cand     (cand_p1),
      .sad_in   (sad_in),
      .best_sad (best_sad),
      .best_idx (best_idx)
   );

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with a 1-cycle memory model and a
// registered SAD unit model in the loop.
module tb_sad_search_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done, rd_en;
   logic [1:0]  cur_addr;
   logic [3:0]  ref_addr;
   logic [9:0]  sad_in;
   logic [11:0] best_sad;
   logic [2:0]  best_idx;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] cur_mem [0:3];
   logic [31:0] ref_mem [0:10];
   logic [31:0] cur_q = '0;
   logic [31:0] ref_q = '0;

   logic        rd_tr   [0:47];
   logic        done_tr [0:47];
   logic        busy_tr [0:47];
   logic [1:0]  cur_tr  [0:47];
   logic [3:0]  ref_tr  [0:47];
   logic [11:0] bs_tr   [0:47];
   logic [2:0]  bi_tr   [0:47];

   sad_search_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rd_en    (rd_en),
      .cur_addr (cur_addr),
      .ref_addr (ref_addr),
      .sad_in   (sad_in),
      .best_sad (best_sad),
      .best_idx (best_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] sad_fn(input logic [31:0] a, input logic [31:0] b);
      int s = 0;
      for (int p = 0; p < 4; p++) begin
         int x = int'(a[p*8 +: 8]);
         int y = int'(b[p*8 +: 8]);
         s += (x > y) ? (x - y) : (y - x);
      end
      return 10'(s);
   endfunction

   always @(posedge clk) begin
      if (rd_en) begin
         cur_q <= cur_mem[cur_addr];
         ref_q <= ref_mem[ref_addr];
      end
      sad_in <= sad_fn(cur_q, ref_q);
   end

   // mode 0: exact match at offset 3; 1: all-equal (SAD 16); 2: max values;
   // 3: reference rows descending so the last candidate wins.
   task automatic load_mem(input int mode);
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < 4; p++)
            case (mode)
               0:       cur_mem[r][p*8 +: 8] = 8'(20*r + p + 1);
               1:       cur_mem[r][p*8 +: 8] = 8'd5;
               2:       cur_mem[r][p*8 +: 8] = 8'd255;
               default: cur_mem[r][p*8 +: 8] = 8'd0;
            endcase
      for (int j = 0; j < 11; j++)
         for (int p = 0; p < 4; p++)
            case (mode)
               0:       ref_mem[j][p*8 +: 8] = (j >= 3 && j <= 6) ? 8'(20*(j-3) + p + 1) : 8'd200;
               1:       ref_mem[j][p*8 +: 8] = 8'd6;
               2:       ref_mem[j][p*8 +: 8] = 8'd0;
               default: ref_mem[j][p*8 +: 8] = 8'(10 - j);
            endcase
   endtask

   // Launches one search and records 45 cycles of outputs; bit i of inj drives
   // start during cycle i after the launch edge.
   task automatic run_search(input logic [47:0] inj);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         rd_tr[i]   = rd_en;
         done_tr[i] = done;
         busy_tr[i] = busy;
         cur_tr[i]  = cur_addr;
         ref_tr[i]  = ref_addr;
         bs_tr[i]   = best_sad;
         bi_tr[i]   = best_idx;
         start      = inj[i];
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
      n_cmp++; if (rd_en !== 1'b0)    begin n_bad++; $display("FAIL reset rd_en: got %b want 0", rd_en); end
      n_cmp++; if (cur_addr !== 2'd0) begin n_bad++; $display("FAIL reset cur_addr: got %0d want 0", cur_addr); end
      n_cmp++; if (ref_addr !== 4'd0) begin n_bad++; $display("FAIL reset ref_addr: got %0d want 0", ref_addr); end
      n_cmp++; if (best_sad !== 12'd0) begin n_bad++; $display("FAIL reset best_sad: got %0d want 0", best_sad); end
      n_cmp++; if (best_idx !== 3'd0) begin n_bad++; $display("FAIL reset best_idx: got %0d want 0", best_idx); end
   endtask

   task automatic test_exact_match;
      load_mem(0);
      run_search('0);
      n_cmp++; if (done_tr[35] !== 1'b1) begin n_bad++; $display("FAIL exact done@35: got %b want 1", done_tr[35]); end
      n_cmp++; if (bi_tr[35] !== 3'd3)   begin n_bad++; $display("FAIL exact best_idx: got %0d want 3", bi_tr[35]); end
      n_cmp++; if (bs_tr[35] !== 12'd0)  begin n_bad++; $display("FAIL exact best_sad: got %0d want 0", bs_tr[35]); end
   endtask

   task automatic test_cycle_count;
      int rd_cnt = 0;
      int done_cnt = 0;
      load_mem(1);
      run_search('0);
      for (int i = 1; i <= 45; i++) begin
         rd_cnt   += int'(rd_tr[i]);
         done_cnt += int'(done_tr[i]);
      end
      n_cmp++; if (rd_cnt !== 32)  begin n_bad++; $display("FAIL count rd_en cycles: got %0d want 32", rd_cnt); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL count done pulses: got %0d want 1", done_cnt); end
      n_cmp++; if (done_tr[35] !== 1'b1) begin n_bad++; $display("FAIL count done@35: got %b want 1", done_tr[35]); end
      for (int i = 1; i <= 32; i++) begin
         n_cmp++;
         if (rd_tr[i] !== 1'b1 || ref_tr[i] !== 4'((i-1)/4 + (i-1)%4) || cur_tr[i] !== 2'((i-1)%4)) begin
            n_bad++;
            $display("FAIL count issue cycle %0d: got rd=%b cur=%0d ref=%0d want rd=1 cur=%0d ref=%0d",
                     i, rd_tr[i], cur_tr[i], ref_tr[i], (i-1)%4, (i-1)/4 + (i-1)%4);
         end
      end
      n_cmp++; if (busy_tr[1] !== 1'b1 || busy_tr[35] !== 1'b1 || busy_tr[36] !== 1'b0)
         begin n_bad++; $display("FAIL count busy window: got %b%b%b want 110", busy_tr[1], busy_tr[35], busy_tr[36]); end
      n_cmp++; if (bs_tr[35] !== 12'd16) begin n_bad++; $display("FAIL equal best_sad: got %0d want 16", bs_tr[35]); end
      n_cmp++; if (bi_tr[35] !== 3'd0)   begin n_bad++; $display("FAIL equal best_idx: got %0d want 0", bi_tr[35]); end
   endtask

   task automatic test_max_values;
      load_mem(2);
      run_search('0);
      n_cmp++; if (bs_tr[35] !== 12'd4080) begin n_bad++; $display("FAIL max best_sad: got %0d want 4080", bs_tr[35]); end
      n_cmp++; if (bi_tr[35] !== 3'd0)     begin n_bad++; $display("FAIL max best_idx: got %0d want 0", bi_tr[35]); end
   endtask

   task automatic test_last_cand;
      load_mem(3);
      run_search('0);
      n_cmp++; if (bs_tr[35] !== 12'd24) begin n_bad++; $display("FAIL last best_sad: got %0d want 24", bs_tr[35]); end
      n_cmp++; if (bi_tr[35] !== 3'd7)   begin n_bad++; $display("FAIL last best_idx: got %0d want 7", bi_tr[35]); end
      n_cmp++; if (bs_tr[45] !== 12'd24 || bi_tr[45] !== 3'd7)
         begin n_bad++; $display("FAIL last held: got %0d/%0d want 24/7", bs_tr[45], bi_tr[45]); end
   endtask

   task automatic test_start_busy;
      logic [47:0] inj = '0;
      int rd_cnt = 0;
      int done_cnt = 0;
      inj[5] = 1'b1; inj[20] = 1'b1; inj[33] = 1'b1; inj[34] = 1'b1; inj[35] = 1'b1;
      load_mem(0);
      run_search(inj);
      for (int i = 1; i <= 45; i++) begin
         rd_cnt   += int'(rd_tr[i]);
         done_cnt += int'(done_tr[i]);
      end
      n_cmp++; if (rd_cnt !== 32)  begin n_bad++; $display("FAIL busy-start rd_en cycles: got %0d want 32", rd_cnt); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy-start done pulses: got %0d want 1", done_cnt); end
      n_cmp++; if (done_tr[35] !== 1'b1) begin n_bad++; $display("FAIL busy-start done@35: got %b want 1", done_tr[35]); end
      n_cmp++; if (ref_tr[6] !== 4'd2 || cur_tr[6] !== 2'd1)
         begin n_bad++; $display("FAIL busy-start addr@6: got cur=%0d ref=%0d want cur=1 ref=2", cur_tr[6], ref_tr[6]); end
      n_cmp++; if (busy_tr[36] !== 1'b0) begin n_bad++; $display("FAIL busy-start relaunch: got busy=%b want 0", busy_tr[36]); end
      n_cmp++; if (bi_tr[35] !== 3'd3 || bs_tr[35] !== 12'd0)
         begin n_bad++; $display("FAIL busy-start result: got %0d/%0d want 0/3", bs_tr[35], bi_tr[35]); end
   endtask

   task automatic test_reset_mid;
      int done_cnt = 0;
      int rd_cnt = 0;
      load_mem(3);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 10; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0)
         begin n_bad++; $display("FAIL midrst ctrl: got busy=%b done=%b rd_en=%b want 000", busy, done, rd_en); end
      n_cmp++; if (cur_addr !== 2'd0 || ref_addr !== 4'd0)
         begin n_bad++; $display("FAIL midrst addr: got cur=%0d ref=%0d want 0/0", cur_addr, ref_addr); end
      n_cmp++; if (best_sad !== 12'd0 || best_idx !== 3'd0)
         begin n_bad++; $display("FAIL midrst result: got %0d/%0d want 0/0", best_sad, best_idx); end
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         done_cnt += int'(done);
         rd_cnt   += int'(rd_en);
      end
      n_cmp++; if (done_cnt !== 0 || rd_cnt !== 0)
         begin n_bad++; $display("FAIL midrst quiet: got done=%0d rd=%0d want 0/0", done_cnt, rd_cnt); end
      load_mem(0);
      run_search('0);
      n_cmp++; if (done_tr[35] !== 1'b1 || bi_tr[35] !== 3'd3 || bs_tr[35] !== 12'd0)
         begin n_bad++; $display("FAIL midrst rerun: got done=%b %0d/%0d want 1 0/3", done_tr[35], bs_tr[35], bi_tr[35]); end
   endtask

   initial begin
      test_reset;
      test_exact_match;
      test_cycle_count;
      test_max_values;
      test_last_cand;
      test_start_busy;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
